// File: rtl/pll_lock_ctrl_if.sv
// Control/status bundle between the PLL lock sequencer and its environment.
// Optional loss counter signals appear only when PLLCTL_LOSS_CNT_EN is defined.
interface pll_lock_ctrl_if #(
  parameter int RW = 2
);
  logic          extlock;
  logic          restart;
  logic          pll_reset;
  logic          sys_rst;
  logic          locked;
  logic          fail;
  logic [RW-1:0] retry_cnt;
  logic [2:0]    state;
`ifdef PLLCTL_LOSS_CNT_EN
  logic          loss_clr;
  logic [7:0]    loss_cnt;

  modport master (
    output extlock, restart, loss_clr,
    input  pll_reset, sys_rst, locked, fail, retry_cnt, state, loss_cnt
  );
  modport slave (
    input  extlock, restart, loss_clr,
    output pll_reset, sys_rst, locked, fail, retry_cnt, state, loss_cnt
  );
`else
  modport master (
    output extlock, restart,
    input  pll_reset, sys_rst, locked, fail, retry_cnt, state
  );
  modport slave (
    input  extlock, restart,
    output pll_reset, sys_rst, locked, fail, retry_cnt, state
  );
`endif
endinterface

// File: rtl/pll_lock_ctrl.sv
// PLL power-up sequencer: reset pulse, lock wait with timeout/retry, stability
// qualification and system reset release. Optional lock-loss counter: PLLCTL_LOSS_CNT_EN.
module pll_lock_ctrl #(
  parameter int RST_CYCLES   = 24,
  parameter int LOCK_TIMEOUT = 24000,
  parameter int LOCK_STABLE  = 1024,
  parameter int SYSRST_HOLD  = 16,
  parameter int MAX_RETRY    = 3
) (
  input  logic            refclk,
  input  logic            reset,
  pll_lock_ctrl_if.slave  bus
);
  localparam int RW   = $clog2(MAX_RETRY + 1);
  localparam int CM1  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CM2  = (LOCK_STABLE > SYSRST_HOLD) ? LOCK_STABLE : SYSRST_HOLD;
  localparam int CMAX = (CM1 > CM2) ? CM1 : CM2;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] HOLD      = CW'(SYSRST_HOLD);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          sync_ff1, lock_s;
  logic          pll_reset_q, sys_rst_q, locked_q, fail_q;
  logic          pll_reset_d, sys_rst_d, locked_d, fail_d;

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      sync_ff1 <= 1'b0;
      lock_s   <= 1'b0;
    end else begin
      sync_ff1 <= bus.extlock;
      lock_s   <= sync_ff1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    retry_d = retry_q;
    case (state_q)
      S_RST: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lock_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            state_d = S_RST;
          end else begin
            state_d = S_FAIL;
          end
        end
      end
      S_STABLE: begin
        if (!lock_s) state_d = S_WAIT;
        else if (cnt_q == STB_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        // Counter only needs to reach the hold length, then parks there.
        if (cnt_q >= HOLD) cnt_d = cnt_q;
        if (!lock_s) begin
          state_d = S_RST;
          retry_d = '0;
        end
      end
      S_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = S_RST;
      end
    endcase
    if (bus.restart) begin
      state_d = S_RST;
      retry_d = '0;
    end
    if (bus.restart || (state_d != state_q)) cnt_d = '0;

    // Outputs are registered from the next state so they align with state_q.
    pll_reset_d = (state_d == S_RST) || (state_d == S_FAIL);
    locked_d    = (state_d == S_RUN);
    fail_d      = (state_d == S_FAIL);
    sys_rst_d   = !((state_d == S_RUN) && (cnt_d >= HOLD));
  end

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      state_q     <= S_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_q   <= sys_rst_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
    end
  end

  assign bus.pll_reset = pll_reset_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.locked    = locked_q;
  assign bus.fail      = fail_q;
  assign bus.retry_cnt = retry_q;
  assign bus.state     = state_q;

`ifdef PLLCTL_LOSS_CNT_EN
  logic [7:0] loss_q;

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      loss_q <= 8'd0;
    end else if (bus.loss_clr) begin
      loss_q <= 8'd0;
    end else if ((state_q == S_RUN) && !lock_s && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign bus.loss_cnt = loss_q;
`endif
endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with small parameters; cycle counts are hand-derived.
module tb_pll_lock_ctrl;
  localparam int RST_CYCLES   = 4;
  localparam int LOCK_TIMEOUT = 32;
  localparam int LOCK_STABLE  = 8;
  localparam int SYSRST_HOLD  = 4;
  localparam int MAX_RETRY    = 2;
  localparam int RW           = $clog2(MAX_RETRY + 1);

  logic refclk = 1'b0;
  logic reset  = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n;

  pll_lock_ctrl_if #(.RW(RW)) bus ();

  pll_lock_ctrl #(
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_STABLE (LOCK_STABLE),
    .SYSRST_HOLD (SYSRST_HOLD),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .refclk(refclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int cycles);
    cycles = 0;
    while (bus.state !== s && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic wait_sysrst_low(input int budget, output int cycles);
    cycles = 0;
    while (bus.sys_rst !== 1'b0 && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic apply_reset(input logic lock_level);
    reset       = 1'b1;
    bus.extlock = lock_level;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},     32'(bus.state),     32'd0);
    check({tag, "_pll_reset"}, 32'(bus.pll_reset), 32'd1);
    check({tag, "_sys_rst"},   32'(bus.sys_rst),   32'd1);
    check({tag, "_locked"},    32'(bus.locked),    32'd0);
    check({tag, "_fail"},      32'(bus.fail),      32'd0);
    check({tag, "_retry"},     32'(bus.retry_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.extlock = 1'b1;
    bus.restart = 1'b0;
`ifdef PLLCTL_LOSS_CNT_EN
    bus.loss_clr = 1'b0;
`endif
    repeat (3) tick();
    check_reset_vals("rst");

    // Clean lock with extlock high throughout
    reset = 1'b0;
    wait_state(3'd1, 100, n);
    check("s1_rst_len", n, 4);
    check("s1_pll_reset_low", 32'(bus.pll_reset), 32'd0);
    wait_state(3'd3, 100, n);
    check("s1_to_run", n, 9);
    check("s1_locked", 32'(bus.locked), 32'd1);
    check("s1_sysrst_at_lock", 32'(bus.sys_rst), 32'd1);
    wait_sysrst_low(100, n);
    check("s1_sysrst_hold", n, 4);
    check("s1_locked_run", 32'(bus.locked), 32'd1);
    check("s1_retry", 32'(bus.retry_cnt), 32'd0);

    // Lock loss in RUN, then re-lock
    bus.extlock = 1'b0;
    wait_state(3'd0, 20, n);
    check("s4_loss_latency", n, 3);
    check("s4_sys_rst", 32'(bus.sys_rst), 32'd1);
    check("s4_locked", 32'(bus.locked), 32'd0);
    check("s4_retry", 32'(bus.retry_cnt), 32'd0);
`ifdef PLLCTL_LOSS_CNT_EN
    check("s4_loss_cnt", 32'(bus.loss_cnt), 32'd1);
`endif
    bus.extlock = 1'b1;
    wait_state(3'd1, 100, n);
    check("s4_rst_len", n, 4);
    wait_state(3'd3, 100, n);
    check("s4_to_run", n, 9);
    wait_sysrst_low(100, n);
    check("s4_sysrst_hold", n, 4);
`ifdef PLLCTL_LOSS_CNT_EN
    bus.loss_clr = 1'b1;
    tick();
    bus.loss_clr = 1'b0;
    check("s4_loss_clr", 32'(bus.loss_cnt), 32'd0);
`endif

    // Glitchy lock: high 5, low 1, high
    apply_reset(1'b0);
    wait_state(3'd1, 100, n);
    check("s3_rst_len", n, 4);
    bus.extlock = 1'b1;
    repeat (5) tick();
    bus.extlock = 1'b0;
    tick();
    bus.extlock = 1'b1;
    tick();
    check("s3_in_stable", 32'(bus.state), 32'd2);
    check("s3_locked0", 32'(bus.locked), 32'd0);
    tick();
    check("s3_back_wait", 32'(bus.state), 32'd1);
    tick();
    check("s3_restable", 32'(bus.state), 32'd2);
    wait_state(3'd3, 100, n);
    check("s3_to_run", n, 8);
    check("s3_retry", 32'(bus.retry_cnt), 32'd0);

    // Timeout and retries down to FAIL
    apply_reset(1'b0);
    wait_state(3'd1, 100, n);
    check("s2_pulse0", n, 4);
    wait_state(3'd0, 100, n);
    check("s2_wait0", n, 32);
    check("s2_retry1", 32'(bus.retry_cnt), 32'd1);
    check("s2_pll_reset1", 32'(bus.pll_reset), 32'd1);
    wait_state(3'd1, 100, n);
    check("s2_pulse1", n, 4);
    wait_state(3'd0, 100, n);
    check("s2_wait1", n, 32);
    check("s2_retry2", 32'(bus.retry_cnt), 32'd2);
    wait_state(3'd1, 100, n);
    check("s2_pulse2", n, 4);
    wait_state(3'd4, 100, n);
    check("s2_wait2", n, 32);
    check("s2_fail", 32'(bus.fail), 32'd1);
    check("s2_fail_pll_reset", 32'(bus.pll_reset), 32'd1);
    check("s2_fail_sys_rst", 32'(bus.sys_rst), 32'd1);
    check("s2_fail_retry", 32'(bus.retry_cnt), 32'd2);
    repeat (5) tick();
    check("s2_fail_sticky", 32'(bus.state), 32'd4);

    // Restart from FAIL, held for two cycles
    bus.restart = 1'b1;
    tick();
    check_reset_vals("s5_restart");
    tick();
    check("s5_restart_held", 32'(bus.state), 32'd0);
    bus.restart = 1'b0;
    wait_state(3'd1, 100, n);
    check("s5_cnt_restart", n, 4);
    wait_state(3'd0, 100, n);
    check("s5_timeout", n, 32);
    check("s5_retry1", 32'(bus.retry_cnt), 32'd1);
    wait_state(3'd1, 100, n);
    repeat (10) tick();
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    check("s5_midwait_state", 32'(bus.state), 32'd0);
    check("s5_midwait_retry", 32'(bus.retry_cnt), 32'd0);
    wait_state(3'd1, 100, n);
    check("s5_midwait_cnt", n, 4);

    // Asynchronous reset in the middle of STABLE
    bus.extlock = 1'b1;
    wait_state(3'd2, 20, n);
    check("s6_to_stable", n, 3);
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("s6_async");
    #10;
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
